cfs_md_arbiter: RTL and testbench

//  Shares one MD (memory-data) slave port between NUM_REQ MD masters (requesters).
//  - Round-robin arbitration; a grant is locked until the granted transfer completes.
//  - Muxes valid/data/offset/size from the winner to the shared port.
//  - Routes ready/err back to the winner only.
//  - Sits in front of the aligner RX MD input, clocked by pclk.

---
 rtl/cfs_md_arbiter.sv | 126 ++++++++++++
 tb/tb_cfs_md_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cfs_md_arbiter.sv
// Round-robin arbiter sharing one MD slave port between NUM_REQ MD masters.
// Optional per-requester saturating error counters: define CFS_MD_ARB_ERR_CNT_EN.
module cfs_md_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 2,
    parameter int CNT_WIDTH  = 16,
    localparam int OFFSET_WIDTH = (DATA_WIDTH / 8 > 1) ? $clog2(DATA_WIDTH / 8) : 1,
    localparam int SIZE_WIDTH   = $clog2(DATA_WIDTH / 8) + 1,
    localparam int GID_WIDTH    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                             pclk,
    input  logic                             reset_n,
    input  logic [NUM_REQ-1:0]               s_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    s_data,
    input  logic [NUM_REQ*OFFSET_WIDTH-1:0]  s_offset,
    input  logic [NUM_REQ*SIZE_WIDTH-1:0]    s_size,
    output logic [NUM_REQ-1:0]               s_ready,
    output logic [NUM_REQ-1:0]               s_err,
    output logic                             m_valid,
    output logic [DATA_WIDTH-1:0]            m_data,
    output logic [OFFSET_WIDTH-1:0]          m_offset,
    output logic [SIZE_WIDTH-1:0]            m_size,
    input  logic                             m_ready,
    input  logic                             m_err,
    output logic [GID_WIDTH-1:0]             grant_id,
    output logic                             busy
`ifdef CFS_MD_ARB_ERR_CNT_EN
    ,
    output logic [NUM_REQ*CNT_WIDTH-1:0]     err_cnt,
    input  logic                             err_cnt_clr
`endif
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t               state;
    logic [GID_WIDTH-1:0] rr_ptr;
    logic [GID_WIDTH-1:0] winner;
    logic [GID_WIDTH-1:0] next_ptr;

    // Lowest valid index at or above rr_ptr wins; otherwise wrap to the lowest valid index.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        winner = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (s_valid[i]) winner = GID_WIDTH'(i);
        end
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (s_valid[i] && GID_WIDTH'(i) >= rr_ptr) winner = GID_WIDTH'(i);
        end
    end

    assign next_ptr = (grant_id == GID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_id + GID_WIDTH'(1);

    // Shared-port mux and handshake return; everything is zero outside GRANT.
    always_comb begin
        m_valid  = 1'b0;
        m_data   = '0;
        m_offset = '0;
        m_size   = '0;
        s_ready  = '0;
        s_err    = '0;
        if (state == GRANT) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant_id == GID_WIDTH'(i)) begin
                    m_valid    = s_valid[i];
                    m_data     = s_data[i*DATA_WIDTH +: DATA_WIDTH];
                    m_offset   = s_offset[i*OFFSET_WIDTH +: OFFSET_WIDTH];
                    m_size     = s_size[i*SIZE_WIDTH +: SIZE_WIDTH];
                    s_ready[i] = m_ready & s_valid[i];
                    s_err[i]   = m_err & m_ready & s_valid[i];
                end
            end
        end
    end

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
            busy     <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            case (state)
                IDLE: begin
                    if (|s_valid) begin
                        grant_id <= winner;
                        state    <= GRANT;
                        busy     <= 1'b1;
                    end
                end
                GRANT: begin
                    // A completed transfer and a requester abort both release the grant.
                    if (!s_valid[grant_id] || m_ready) begin
                        rr_ptr <= next_ptr;
                        state  <= IDLE;
                        busy   <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef CFS_MD_ARB_ERR_CNT_EN
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            err_cnt <= '0;
        end else if (err_cnt_clr) begin
            err_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (s_ready[i] && s_err[i] && err_cnt[i*CNT_WIDTH +: CNT_WIDTH] != '1)
                    err_cnt[i*CNT_WIDTH +: CNT_WIDTH] <= err_cnt[i*CNT_WIDTH +: CNT_WIDTH] + CNT_WIDTH'(1);
            end
        end
    end
`else
    // Default build: no error counters.
`endif

endmodule

// File: tb/tb_cfs_md_arbiter.sv
// Directed bench for cfs_md_arbiter; a negedge monitor scores every shared-port handshake.
// Counter checks are compiled only when CFS_MD_ARB_ERR_CNT_EN is defined.
module tb_cfs_md_arbiter;

    localparam int DW = 32;
    localparam int NR = 2;
    localparam int CW = 4;
    localparam int OW = 2;
    localparam int SW = 3;
    localparam int GW = 1;

    typedef struct {
        int             id;
        logic [DW-1:0]  data;
        logic [OW-1:0]  off;
        logic [SW-1:0]  size;
        logic           err;
    } xfer_t;

    logic              pclk;
    logic              reset_n;
    logic [NR-1:0]     s_valid;
    logic [NR*DW-1:0]  s_data;
    logic [NR*OW-1:0]  s_offset;
    logic [NR*SW-1:0]  s_size;
    logic [NR-1:0]     s_ready;
    logic [NR-1:0]     s_err;
    logic              m_valid;
    logic [DW-1:0]     m_data;
    logic [OW-1:0]     m_offset;
    logic [SW-1:0]     m_size;
    logic              m_ready;
    logic              m_err;
    logic [GW-1:0]     grant_id;
    logic              busy;
`ifdef CFS_MD_ARB_ERR_CNT_EN
    logic [NR*CW-1:0]  err_cnt;
    logic              err_cnt_clr;
`endif

    int    checks = 0;
    int    errors = 0;
    xfer_t sb[$];

    cfs_md_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .CNT_WIDTH(CW)) dut (
        .pclk     (pclk),
        .reset_n  (reset_n),
        .s_valid  (s_valid),
        .s_data   (s_data),
        .s_offset (s_offset),
        .s_size   (s_size),
        .s_ready  (s_ready),
        .s_err    (s_err),
        .m_valid  (m_valid),
        .m_data   (m_data),
        .m_offset (m_offset),
        .m_size   (m_size),
        .m_ready  (m_ready),
        .m_err    (m_err),
        .grant_id (grant_id),
        .busy     (busy)
`ifdef CFS_MD_ARB_ERR_CNT_EN
        ,
        .err_cnt     (err_cnt),
        .err_cnt_clr (err_cnt_clr)
`endif
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    task automatic drive_req(input int id, input logic [DW-1:0] data, input logic [OW-1:0] off,
                             input logic [SW-1:0] size);
        s_data[id*DW +: DW]   = data;
        s_offset[id*OW +: OW] = off;
        s_size[id*SW +: SW]   = size;
        s_valid[id]           = 1'b1;
    endtask

    task automatic expect_xfer(input int id, input logic [DW-1:0] data, input logic [OW-1:0] off,
                               input logic [SW-1:0] size, input logic err);
        xfer_t x;
        x.id = id; x.data = data; x.off = off; x.size = size; x.err = err;
        sb.push_back(x);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    // Scoreboard: each shared-port handshake must match the oldest expected transfer.
    always @(negedge pclk) begin
        if (m_valid && m_ready) begin
            check("sb_pending", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                xfer_t e;
                e = sb.pop_front();
                check("sb_grant_id", 64'(grant_id), 64'(e.id));
                check("sb_m_data",   64'(m_data),   64'(e.data));
                check("sb_m_offset", 64'(m_offset), 64'(e.off));
                check("sb_m_size",   64'(m_size),   64'(e.size));
                check("sb_s_ready",  64'(s_ready),  64'(2'b01 << e.id));
                check("sb_s_err",    64'(s_err),    e.err ? 64'(2'b01 << e.id) : 64'd0);
            end
        end
    end

    initial begin
        logic [DW-1:0] d [NR];

        reset_n  = 1'b0;
        s_valid  = '0;
        s_data   = '0;
        s_offset = '0;
        s_size   = '0;
        m_ready  = 1'b0;
        m_err    = 1'b0;
`ifdef CFS_MD_ARB_ERR_CNT_EN
        err_cnt_clr = 1'b0;
`endif
        tick(2);
        check("rst_m_valid",  64'(m_valid),  64'd0);
        check("rst_m_data",   64'(m_data),   64'd0);
        check("rst_s_ready",  64'(s_ready),  64'd0);
        check("rst_s_err",    64'(s_err),    64'd0);
        check("rst_busy",     64'(busy),     64'd0);
        check("rst_grant_id", 64'(grant_id), 64'd0);
        reset_n = 1'b1;
        tick();

        // Single request from requester 0; m_ready in IDLE must be ignored.
        m_ready = 1'b1;
        drive_req(0, 32'h1122_3344, 2'd1, 3'd4);
        expect_xfer(0, 32'h1122_3344, 2'd1, 3'd4, 1'b0);
        #1;
        check("t1_idle_m_valid", 64'(m_valid), 64'd0);
        check("t1_idle_s_ready", 64'(s_ready), 64'd0);
        tick();
        check("t1_m_valid",  64'(m_valid),  64'd1);
        check("t1_m_data",   64'(m_data),   64'h1122_3344);
        check("t1_s_ready",  64'(s_ready),  64'b01);
        check("t1_grant_id", 64'(grant_id), 64'd0);
        check("t1_busy",     64'(busy),     64'd1);
        tick();
        s_valid = '0;
        #1;
        check("t1_busy_done", 64'(busy), 64'd0);

        // Both requesters always valid from reset: grants alternate 0,1,0,1.
        do_reset();
        d[0] = 32'hA000_0000;
        d[1] = 32'hB000_0000;
        drive_req(0, d[0], 2'd0, 3'd1);
        drive_req(1, d[1], 2'd2, 3'd2);
        for (int k = 0; k < 4; k++) begin
            int id;
            id = k % 2;
            expect_xfer(id, d[id], (id == 0) ? 2'd0 : 2'd2, (id == 0) ? 3'd1 : 3'd2, 1'b0);
            tick();
            check("t2_grant_id", 64'(grant_id), 64'(id));
            check("t2_s_ready",  64'(s_ready),  64'(2'b01 << id));
            tick();
            check("t2_gap_s_ready", 64'(s_ready), 64'd0);
            d[id] = d[id] + 32'd1;
            s_data[id*DW +: DW] = d[id];
        end
        s_valid = '0;

        // Requester 1 stalled by m_ready=0 for five cycles, accepted in the sixth.
        m_ready = 1'b0;
        drive_req(1, 32'hCAFE_F00D, 2'd3, 3'd3);
        expect_xfer(1, 32'hCAFE_F00D, 2'd3, 3'd3, 1'b0);
        tick();
        for (int c = 0; c < 5; c++) begin
            check("t3_m_valid",  64'(m_valid),  64'd1);
            check("t3_m_data",   64'(m_data),   64'hCAFE_F00D);
            check("t3_s_ready",  64'(s_ready),  64'd0);
            check("t3_grant_id", 64'(grant_id), 64'd1);
            tick();
        end
        m_ready = 1'b1;
        #1;
        check("t3_s_ready_c6", 64'(s_ready), 64'b10);
        tick();
        s_valid = '0;

        // Requester 0 aborts its grant; the round-robin pointer still advances past it.
        m_ready = 1'b0;
        drive_req(0, 32'hDEAD_0000, 2'd0, 3'd4);
        tick();
        check("t5_grant_id", 64'(grant_id), 64'd0);
        check("t5_m_valid",  64'(m_valid),  64'd1);
        s_valid = 2'b00;
        drive_req(1, 32'h5555_AAAA, 2'd1, 3'd2);
        #1;
        check("t5_abort_m_valid", 64'(m_valid), 64'd0);
        check("t5_abort_s_ready", 64'(s_ready), 64'd0);
        tick();
        check("t5_idle_busy", 64'(busy), 64'd0);
        drive_req(0, 32'hDEAD_0001, 2'd0, 3'd4);
        m_ready = 1'b1;
        expect_xfer(1, 32'h5555_AAAA, 2'd1, 3'd2, 1'b0);
        tick();
        check("t5_next_grant", 64'(grant_id), 64'd1);
        tick();
        s_valid = '0;

        // Error response on requester 0's transfer; m_err in IDLE must not leak.
        m_err = 1'b1;
        drive_req(0, 32'h0BAD_0BAD, 2'd2, 3'd1);
        expect_xfer(0, 32'h0BAD_0BAD, 2'd2, 3'd1, 1'b1);
        #1;
        check("t4_idle_s_err", 64'(s_err), 64'd0);
        tick();
        check("t4_s_err",   64'(s_err),   64'b01);
        check("t4_s_ready", 64'(s_ready), 64'b01);
        tick();
        s_valid = '0;
        m_err   = 1'b0;
`ifdef CFS_MD_ARB_ERR_CNT_EN
        #1;
        check("t4_err_cnt0", 64'(err_cnt[0 +: CW]),  64'd1);
        check("t4_err_cnt1", 64'(err_cnt[CW +: CW]), 64'd0);
`endif

        // Reset during a live grant to requester 1 drops it; first grant afterwards is requester 0.
        m_ready = 1'b0;
        drive_req(1, 32'h7777_7777, 2'd0, 3'd4);
        tick();
        check("t6_pre_m_valid", 64'(m_valid), 64'd1);
        reset_n = 1'b0;
        m_ready = 1'b1;
        #1;
        check("t6_rst_m_valid",  64'(m_valid),  64'd0);
        check("t6_rst_s_ready",  64'(s_ready),  64'd0);
        check("t6_rst_busy",     64'(busy),     64'd0);
        check("t6_rst_grant_id", 64'(grant_id), 64'd0);
        tick();
        reset_n = 1'b1;
        drive_req(0, 32'h1234_5678, 2'd3, 3'd2);
        expect_xfer(0, 32'h1234_5678, 2'd3, 3'd2, 1'b0);
        tick();
        check("t6_first_grant", 64'(grant_id), 64'd0);
        tick();
        s_valid = '0;

`ifdef CFS_MD_ARB_ERR_CNT_EN
        // Sixteen error transfers saturate a 4-bit counter at 0xF; clear zeroes it.
        m_err = 1'b1;
        drive_req(0, 32'hE0E0_E0E0, 2'd0, 3'd4);
        for (int k = 0; k < 16; k++) begin
            expect_xfer(0, 32'hE0E0_E0E0, 2'd0, 3'd4, 1'b1);
            tick(2);
        end
        s_valid = '0;
        m_err   = 1'b0;
        check("cnt_sat0", 64'(err_cnt[0 +: CW]),  64'hF);
        check("cnt_sat1", 64'(err_cnt[CW +: CW]), 64'd0);
        err_cnt_clr = 1'b1;
        tick();
        err_cnt_clr = 1'b0;
        check("cnt_clr0", 64'(err_cnt[0 +: CW]), 64'd0);
`endif

        tick(2);
        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
